pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have the following ports (name direction width meaning), clock and reset first:
REQ-002 clk  in  1  single core clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-004 dec_nstall  in  1  decode has no load-use hazard (1 = no hazard).
REQ-005 br_taken  in  1  redirect (taken branch or jump) resolved this cycle.
REQ-006 mc_start  in  1  multicycle op issued from decode into execute this cycle.
REQ-007 mc_lat  in  4  execute latency of that op in cycles, unsigned.
REQ-008 mem_busy  in  1  data memory not ready this cycle.
REQ-009 ext_halt  in  1  external halt request, level-sensitive.
REQ-010 n_stall  out  1  pipeline advance enable for decode and later stages.
REQ-011 flush  out  1  kill the instruction currently in decode.
REQ-012 pc_we  out  1  fetch PC update enable.
REQ-013 state  out  2  current FSM state, for debug.
REQ-014 stall_cycles  out  32  stall cycle counter (see Configuration).
REQ-015 flush_count  out  32  flush event counter (see Configuration).

Function
REQ-016 FSM states SHALL be RUN=0, MC_WAIT=1, HALT=2; encoding 3 is unused and SHALL return to RUN.
REQ-017 n_stall SHALL be combinational: 1 only in RUN with mem_busy=0; 0 in MC_WAIT and HALT.
REQ-018 In RUN with n_stall=1, flush=0 and mc_start=1, mc_lat>=2 SHALL load the counter with mc_lat-1 and enter MC_WAIT; mc_lat of 0 or 1 SHALL stay in RUN.
REQ-019 In MC_WAIT, the counter SHALL decrement each cycle; the FSM SHALL return to RUN on the edge where counter==1. Total n_stall=0 window = mc_lat-1 cycles.
REQ-020 In RUN with no MC_WAIT entry, ext_halt=1 SHALL enter HALT next cycle; HALT SHALL exit to RUN on the first cycle ext_halt=0.
REQ-021 ext_halt during MC_WAIT SHALL be deferred until MC_WAIT completes; MC_WAIT has priority.
REQ-022 flush SHALL be br_taken & n_stall.
REQ-023 br_taken while n_stall=0 SHALL set flush_pend; flush_pend SHALL raise flush on the first n_stall=1 cycle, then clear. A new br_taken in that cycle SHALL not double-count.
REQ-024 mc_start in a cycle with flush=1 SHALL be ignored, because the op is killed.
REQ-025 pc_we SHALL be n_stall & (dec_nstall | flush); on a flush, redirect wins over a load-use hold.
REQ-026 mem_busy SHALL not change FSM state; it only gates n_stall.

Reset
REQ-027 With rst=0 at a rising edge: state=RUN, counter=0, flush_pend=0, stall_cycles=0, flush_count=0.
REQ-028 While rst=0, n_stall, flush and pc_we SHALL be driven 0.
REQ-029 Reset asserted during MC_WAIT or HALT SHALL abort it; the first cycle after release SHALL be in RUN.

Configuration
REQ-030 Macro PIPE_PERF_EN SHALL control the performance counters.
REQ-031 With PIPE_PERF_EN defined: stall_cycles SHALL increment on every non-reset cycle with n_stall=0, and flush_count SHALL increment on every flush=1 cycle. Both are 32-bit and wrap modulo 2^32.
REQ-032 Without PIPE_PERF_EN: both outputs SHALL be constant 0, and no counter flops SHALL be synthesized.

Structure
REQ-033 Package pipe_pkg SHALL hold the state enum (RUN, MC_WAIT, HALT), MC_LAT_W=4 and PERF_W=32.
REQ-034 Sub-module perf_counter (enable, clear, value) SHALL be instantiated twice under PIPE_PERF_EN; everything else stays in pipe_ctrl.

Verification
REQ-035 mc_start=1, mc_lat=4 in RUN: n_stall=0 for exactly 3 cycles, then RUN; stall_cycles=3 (PERF).
REQ-036 br_taken=1 during a mem_busy=1 cycle, mem_busy drops next cycle: flush=1 on that cycle, flush_count=1, pc_we=1.
REQ-037 dec_nstall=0, br_taken=0, mem_busy=0: n_stall=1, pc_we=0; with br_taken=1 added: pc_we=1, flush=1.
REQ-038 mc_start=1 and br_taken=1 same cycle with mc_lat=5: flush=1, FSM stays RUN, no stall.
REQ-039 ext_halt=1 asserted mid MC_WAIT (mc_lat=6): HALT entered the cycle after MC_WAIT ends; state=2 until ext_halt=0.
REQ-040 rst=0 pulsed during MC_WAIT: state=0, counters=0, n_stall=1 on the first cycle after release with mem_busy=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline control block.
package pipe_pkg;
  localparam int MC_LAT_W = 4;
  localparam int PERF_W   = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    HALT    = 2'd2
  } state_t;
endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with synchronous clear; wraps modulo 2^W.
module perf_counter
  import pipe_pkg::*;
#(
  parameter int W = PERF_W
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (clear) begin
      value <= '0;
    end else if (enable) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/PC-enable controller with multicycle wait and halt.
// Define PIPE_PERF_EN to build the stall and flush performance counters.
module pipe_ctrl
  import pipe_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_nstall,
  input  logic                br_taken,
  input  logic                mc_start,
  input  logic [MC_LAT_W-1:0] mc_lat,
  input  logic                mem_busy,
  input  logic                ext_halt,
  output logic                n_stall,
  output logic                flush,
  output logic                pc_we,
  output logic [1:0]          state,
  output logic [PERF_W-1:0]   stall_cycles,
  output logic [PERF_W-1:0]   flush_count
);

  state_t              state_reg, state_next;
  logic [MC_LAT_W-1:0] count_reg, count_next;
  logic                flush_pend_reg, flush_pend_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg      <= RUN;
      count_reg      <= '0;
      flush_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

  always_comb begin
    n_stall         = rst & (state_reg == RUN) & ~mem_busy;
    // A redirect seen while stalled is held until the pipe can advance.
    flush           = n_stall & (br_taken | flush_pend_reg);
    pc_we           = n_stall & (dec_nstall | flush);
    flush_pend_next = n_stall ? 1'b0 : (flush_pend_reg | br_taken);
    state_next      = state_reg;
    count_next      = count_reg;
    case (state_reg)
      RUN: begin
        // A killed op never starts its latency window.
        if (n_stall && !flush && mc_start && (mc_lat >= MC_LAT_W'(2))) begin
          state_next = MC_WAIT;
          count_next = mc_lat - MC_LAT_W'(1);
        end else if (ext_halt) begin
          state_next = HALT;
        end
      end
      MC_WAIT: begin
        count_next = count_reg - MC_LAT_W'(1);
        if (count_reg == MC_LAT_W'(1)) begin
          state_next = RUN;
        end
      end
      HALT: begin
        if (!ext_halt) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        count_next = '0;
      end
    endcase
  end

  assign state = state_reg;

`ifdef PIPE_PERF_EN
  perf_counter #(.W(PERF_W)) u_stall_cnt (
    .clk    (clk),
    .clear  (~rst),
    .enable (~n_stall),
    .value  (stall_cycles)
  );

  perf_counter #(.W(PERF_W)) u_flush_cnt (
    .clk    (clk),
    .clear  (~rst),
    .enable (flush),
    .value  (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
